// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RISC-V control path (single-cycle and multicycle).
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
// Contents: opcode constants, mux/ALU encodings, multicycle state enum, ImmSrc helper.
package riscv_ctrl_pkg;

  // Opcodes of the supported instruction subset
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB,
    S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_BRANCH, S_JAL, S_LUI_WB, S_TRAP
  } state_t;

  // Immediate format implied by the opcode; R-type and unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      OP_LUI:  return IMM_U;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from opcode/funct3/funct7[5].
// Latency: combinational.
// Backpressure: none.
// Ports: opcode, funct3, funct7_5 in; alu_control out.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // Bit 30 is part of the immediate for I-type, so only R-type may select SUB.
      3'b000:  alu_control = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_SLL;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V sequencer: fetch/decode/execute/memory/writeback over one shared memory port.
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: holds mem_req and address controls until mem_ready; traps after MEM_TIMEOUT wait cycles.
// Ports: clk, rst_n; IR fields opcode/funct3/funct7_5, Zero, mem_ready in;
//        mem_req, datapath mux selects/enables, instr_done pulse, sticky trap out.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       trap
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t           state, state_nxt;
  logic             run;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic [2:0]       dec_alu_control;

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (dec_alu_control)
  );

  // run is low during reset and for the first clock after release, so every
  // output (mem_req included) is held at 0 until one full cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      run      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      run      <= 1'b1;
    end
  end

  assign cnt_inc = {1'b0, wait_cnt} + (CNT_W + 1)'(1);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    mem_req      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    ImmSrc       = IMM_I;
    ResultSrc    = RES_ALUOUT;
    ALUControl   = ALU_ADD;
    instr_done   = 1'b0;
    trap         = 1'b0;

    if (run) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
          if (mem_ready) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          // ALUOut captures OldPC+imm for the branch/jump target.
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = imm_src_of(opcode);
          case (opcode)
            OP_R:         state_nxt = S_EXEC_R;
            OP_I:         state_nxt = S_EXEC_I;
            OP_LW, OP_SW: state_nxt = S_MEM_ADR;
            OP_BEQ:       state_nxt = S_BRANCH;
            OP_JAL:       state_nxt = S_JAL;
            OP_LUI:       state_nxt = S_LUI_WB;
            default:      state_nxt = S_TRAP;
          endcase
        end
        S_EXEC_R: begin
          ALUSrcA    = SRCA_RD1;
          ALUSrcB    = SRCB_RD2;
          ALUControl = dec_alu_control;
          state_nxt  = S_ALU_WB;
        end
        S_EXEC_I: begin
          ALUSrcA    = SRCA_RD1;
          ALUSrcB    = SRCB_IMM;
          ImmSrc     = IMM_I;
          ALUControl = dec_alu_control;
          state_nxt  = S_ALU_WB;
        end
        S_ALU_WB: begin
          ResultSrc  = RES_ALUOUT;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_MEM_ADR: begin
          ALUSrcA   = SRCA_RD1;
          ALUSrcB   = SRCB_IMM;
          ImmSrc    = (opcode == OP_SW) ? IMM_S : IMM_I;
          state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
          if (mem_ready) state_nxt = S_MEM_WB;
        end
        S_MEM_WB: begin
          ResultSrc  = RES_DATA;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end
        end
        S_BRANCH: begin
          ALUSrcA    = SRCA_RD1;
          ALUSrcB    = SRCB_RD2;
          ALUControl = ALU_SUB;
          ResultSrc  = RES_ALUOUT;
          PCWrite    = Zero;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_JAL: begin
          // PC <- target held in ALUOut; ALU forms OldPC+4 for the link write.
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALUOUT;
          PCWrite   = 1'b1;
          state_nxt = S_ALU_WB;
        end
        S_LUI_WB: begin
          ImmSrc     = IMM_U;
          ResultSrc  = RES_IMM;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: state_nxt = S_TRAP;
      endcase

      // Wait counting; a stall cycle that brings the count to the limit traps
      // instead of waiting further. mem_ready on that cycle is not a stall.
      if (mem_req && !mem_ready) begin
        wait_cnt_nxt = cnt_inc[CNT_W-1:0];
        if (MEM_TIMEOUT != 0 && cnt_inc == (CNT_W + 1)'(MEM_TIMEOUT))
          state_nxt = S_TRAP;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller (MEM_TIMEOUT = 4).
// Expected control words come from a per-phase table of the instruction flow.
// Directed cases first, then randomized instructions with random memory waits.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc, ALUControl;
  logic       instr_done, trap;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .instr_done(instr_done), .trap(trap)
  );

  typedef struct packed {
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0] src_a, src_b;
    logic [2:0] imm_src;
    logic [1:0] res_src;
    logic [2:0] alu;
    logic       done, trap;
  } ctl_t;

  typedef enum int {P_FETCH, P_DECODE, P_EXR, P_EXI, P_ALUWB, P_MADR,
                    P_MRD, P_MWB, P_MWR, P_BR, P_JAL, P_LUI, P_TRAP} phase_e;

  localparam logic [6:0] R = 7'h33, I = 7'h13, LW = 7'h03, SW = 7'h23,
                         BEQ = 7'h63, JAL = 7'h6f, LUI = 7'h37, ILL = 7'h73;

  ctl_t obs;
  assign obs = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
                ImmSrc, ResultSrc, ALUControl, instr_done, trap};

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int seen_done = 0;

  always @(negedge clk) if (instr_done === 1'b1) seen_done++;

  function automatic logic [2:0] alu_ref(logic [6:0] op, logic [2:0] f3, logic f75);
    logic [2:0] tbl [8];
    tbl = '{3'b000, 3'b110, 3'b101, 3'b000, 3'b000, 3'b000, 3'b011, 3'b010};
    if (f3 == 3'd0 && op == R && f75) return 3'b001;
    return tbl[f3];
  endfunction

  function automatic logic [2:0] imm_ref(logic [6:0] op);
    if (op == SW)  return 3'b001;
    if (op == BEQ) return 3'b010;
    if (op == JAL) return 3'b011;
    if (op == LUI) return 3'b100;
    return 3'b000;
  endfunction

  function automatic ctl_t exp_word(phase_e p, logic [6:0] op, logic [2:0] f3, logic f75,
                                    logic z, logic rdy);
    ctl_t e;
    e = '0;
    case (p)
      P_FETCH:  begin e.mem_req = 1; e.src_b = 2; e.res_src = 2; e.ir_write = rdy; e.pc_write = rdy; end
      P_DECODE: begin e.src_a = 1; e.src_b = 1; e.imm_src = imm_ref(op); end
      P_EXR:    begin e.src_a = 2; e.src_b = 0; e.alu = alu_ref(op, f3, f75); end
      P_EXI:    begin e.src_a = 2; e.src_b = 1; e.alu = alu_ref(op, f3, f75); end
      P_ALUWB:  begin e.reg_write = 1; e.done = 1; end
      P_MADR:   begin e.src_a = 2; e.src_b = 1; e.imm_src = (op == SW) ? 3'b001 : 3'b000; end
      P_MRD:    begin e.mem_req = 1; e.adr_src = 1; end
      P_MWB:    begin e.res_src = 1; e.reg_write = 1; e.done = 1; end
      P_MWR:    begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; e.done = rdy; end
      P_BR:     begin e.src_a = 2; e.alu = 3'b001; e.pc_write = z; e.done = 1; end
      P_JAL:    begin e.src_a = 1; e.src_b = 2; e.pc_write = 1; end
      P_LUI:    begin e.imm_src = 3'b100; e.res_src = 3; e.reg_write = 1; e.done = 1; end
      P_TRAP:   begin e.trap = 1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    check({tag, "_rst_low"}, '0);
    tick();
    rst_n = 1'b1;
    check({tag, "_rst_release"}, '0);
    tick();
  endtask

  // Walks one instruction through its phase sequence; wf/wm are the wait
  // cycles inserted on the fetch and on the data access respectively.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f75, input logic z, input int wf, input int wm);
    phase_e ph[$];
    ctl_t   e;
    ph = '{P_FETCH, P_DECODE};
    case (op)
      R:   begin ph.push_back(P_EXR); ph.push_back(P_ALUWB); end
      I:   begin ph.push_back(P_EXI); ph.push_back(P_ALUWB); end
      LW:  begin ph.push_back(P_MADR); ph.push_back(P_MRD); ph.push_back(P_MWB); end
      SW:  begin ph.push_back(P_MADR); ph.push_back(P_MWR); end
      BEQ: ph.push_back(P_BR);
      JAL: begin ph.push_back(P_JAL); ph.push_back(P_ALUWB); end
      default: ph.push_back(P_LUI);
    endcase
    opcode = op; funct3 = f3; funct7_5 = f75; Zero = z;
    foreach (ph[i]) begin
      if (ph[i] == P_FETCH || ph[i] == P_MRD || ph[i] == P_MWR) begin
        for (int k = 0; k < ((ph[i] == P_FETCH) ? wf : wm); k++) begin
          mem_ready = 1'b0;
          check($sformatf("%s_ph%0d_wait%0d", tag, i, k), exp_word(ph[i], op, f3, f75, z, 1'b0));
          tick();
        end
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      e = exp_word(ph[i], op, f3, f75, z, mem_ready);
      check($sformatf("%s_ph%0d", tag, i), e);
      if (e.done) exp_done++;
      tick();
    end
  endtask

  initial begin
    logic [6:0] ops [7];
    ctl_t       e;
    ops = '{R, I, LW, SW, BEQ, JAL, LUI};
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", '0);
    do_reset("init");

    // Directed instruction flows
    run_instr("add",       R,   3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("sub",       R,   3'b000, 1'b1, 1'b0, 0, 0);
    run_instr("addi_b30",  I,   3'b000, 1'b1, 1'b0, 0, 0);
    run_instr("lw_wait3",  LW,  3'b010, 1'b0, 1'b0, 0, 3);
    run_instr("beq_taken", BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr("beq_not",   BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("sw_wait2",  SW,  3'b010, 1'b0, 1'b0, 1, 2);
    run_instr("jal",       JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("lui",       LUI, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("slt_r",     R,   3'b010, 1'b1, 1'b0, 0, 0);
    run_instr("and_i",     I,   3'b111, 1'b0, 1'b0, 0, 0);
    // Ready arriving on the cycle the wait count would hit the limit still completes
    run_instr("fetch_edge", R,  3'b110, 1'b0, 1'b0, 3, 0);

    // Randomized instruction stream, waits kept below the timeout
    for (int n = 0; n < 40; n++) begin
      run_instr($sformatf("rnd%0d", n), ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset in the middle of a store handshake drops the strobes at once
    opcode = SW; funct3 = 3'b010; funct7_5 = 1'b0; Zero = 1'b0;
    mem_ready = 1'b1; check("midwr_fetch", exp_word(P_FETCH, SW, 3'b010, 1'b0, 1'b0, 1'b1)); tick();
    check("midwr_decode", exp_word(P_DECODE, SW, 3'b010, 1'b0, 1'b0, 1'b0)); tick();
    check("midwr_adr", exp_word(P_MADR, SW, 3'b010, 1'b0, 1'b0, 1'b0)); tick();
    mem_ready = 1'b0;
    check("midwr_wait", exp_word(P_MWR, SW, 3'b010, 1'b0, 1'b0, 1'b0));
    do_reset("midwr");
    run_instr("after_midwr", R, 3'b001, 1'b0, 1'b0, 0, 0);

    // Illegal opcode: trap after decode, sticky until reset
    opcode = ILL; mem_ready = 1'b1;
    check("ill_fetch", exp_word(P_FETCH, ILL, 3'b000, 1'b0, 1'b0, 1'b1)); tick();
    check("ill_decode", exp_word(P_DECODE, ILL, 3'b000, 1'b0, 1'b0, 1'b0)); tick();
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      check($sformatf("ill_trap%0d", k), exp_word(P_TRAP, ILL, 3'b000, 1'b0, 1'b0, 1'b0));
      tick();
    end
    do_reset("ill");
    run_instr("after_ill", LUI, 3'b000, 1'b0, 1'b0, 0, 0);

    // Fetch timeout: four stall cycles, then trap with no IR/PC write
    mem_ready = 1'b0; opcode = R;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tmo_wait%0d", k), exp_word(P_FETCH, R, 3'b000, 1'b0, 1'b0, 1'b0));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      check($sformatf("tmo_trap%0d", k), exp_word(P_TRAP, R, 3'b000, 1'b0, 1'b0, 1'b0));
      tick();
    end
    do_reset("tmo");
    run_instr("after_tmo", BEQ, 3'b000, 1'b0, 1'b1, 0, 0);

    @(negedge clk);
    checks++;
    assert (seen_done == exp_done) else begin
      errors++;
      $error("FAIL instr_done_count: observed %0d expected %0d", seen_done, exp_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
